instruction_issue_sequencer: RTL and testbench

//  Upstream stage of the ControlUnit. Buffers 7-bit instructions ({store,op[1:0],X[1:0],Y[1:0]})

---
 rtl/instruction_issue_sequencer.sv | 142 ++++++++++++++
 tb/tb_instruction_issue_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instruction_issue_sequencer.sv
// Instruction FIFO plus issue FSM feeding the ControlUnit FUNCTION/W handshake, with a done watchdog.
// Optional `SINGLE_STEP_EN adds a step input gating each issue.
module instruction_issue_sequencer #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [6:0] instr_in,
    input  logic       instr_wr,
    input  logic       run,
    input  logic       done_in,
`ifdef SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic [6:0] func_out,
    output logic       w_out,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       busy,
    output logic       overflow,
    output logic       timeout_err,
    output logic [7:0] issued_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [6:0]    func_q, func_d;
    logic          w_q, w_d;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    issued_q, issued_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [6:0]    mem_q [DEPTH];

    logic issue_ok, pop, wr_en, full, empty;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
`ifdef SINGLE_STEP_EN
        issue_ok = run & step & ~empty;
`else
        issue_ok = run & ~empty;
`endif
        pop   = (state_q == IDLE) & issue_ok;
        wr_en = instr_wr & (~full | pop);

        rd_ptr_d   = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d    = count_q;
        if (wr_en && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !wr_en)
            count_d = count_q - CW'(1);
        overflow_d = overflow_q | (instr_wr & full & ~pop);

        state_d   = state_q;
        func_d    = func_q;
        w_d       = 1'b0;
        timeout_d = timeout_q;
        issued_d  = issued_q;
        wd_d      = wd_q;

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = ISSUE;
                    func_d  = mem_q[rd_ptr_q];
                    w_d     = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wd_d    = '0;
            end
            WAIT: begin
                if (done_in) begin
                    state_d  = IDLE;
                    issued_d = issued_q + 8'd1;
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            func_q     <= '0;
            w_q        <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            issued_q   <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            func_q     <= func_d;
            w_q        <= w_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            issued_q   <= issued_d;
            wd_q       <= wd_d;
        end
    end

    // Storage needs no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (!clr && wr_en)
            mem_q[wr_ptr_q] <= instr_in;
    end

    assign func_out    = func_q;
    assign w_out       = w_q;
    assign fifo_full   = full;
    assign fifo_empty  = empty;
    assign busy        = (state_q != IDLE);
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;
    assign issued_cnt  = issued_q;

endmodule

// File: tb/tb_instruction_issue_sequencer.sv
// Scoreboard bench for instruction_issue_sequencer: queue-based reference model, negedge monitor.
module tb_instruction_issue_sequencer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       clr, instr_wr, run, done_in;
    logic [6:0] instr_in;
`ifdef SINGLE_STEP_EN
    logic       step;
`endif
    logic [6:0] func_out;
    logic       w_out, fifo_full, fifo_empty, busy, overflow, timeout_err;
    logic [7:0] issued_cnt;

    instruction_issue_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .clr(clr), .instr_in(instr_in), .instr_wr(instr_wr),
        .run(run), .done_in(done_in),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .func_out(func_out), .w_out(w_out), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .busy(busy), .overflow(overflow),
        .timeout_err(timeout_err), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 0;

    // Reference model: queue holds pending instructions; phase 0=idle,1=issuing,2=waiting.
    logic [6:0] mq[$];
    logic [6:0] exp_q[$];
    int         ph = 0, wd = 0;
    logic [6:0] m_func = '0;
    bit         m_w = 0, m_ovf = 0, m_to = 0;
    logic [7:0] m_cnt = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit c, input bit wr, input logic [6:0] d,
                              input bit r, input bit dn, input bit st);
        bit         can_pop;
        logic [6:0] head;
        if (c) begin
            mq.delete();
            ph = 0; wd = 0; m_func = '0; m_w = 0; m_ovf = 0; m_to = 0; m_cnt = '0;
            return;
        end
`ifdef SINGLE_STEP_EN
        can_pop = (ph == 0) && r && st && (mq.size() > 0);
`else
        can_pop = (ph == 0) && r && (mq.size() > 0);
`endif
        head = can_pop ? mq[0] : 7'd0;
        if (wr) begin
            if (mq.size() < DEPTH || can_pop) mq.push_back(d);
            else m_ovf = 1;
        end
        if (can_pop) void'(mq.pop_front());
        m_w = 0;
        if (ph == 0) begin
            if (can_pop) begin
                ph = 1; m_func = head; m_w = 1;
                exp_q.push_back(head);
            end
        end else if (ph == 1) begin
            ph = 2; wd = 0;
        end else begin
            if (dn) begin
                ph = 0; m_cnt = m_cnt + 8'd1;
            end else if (wd == TIMEOUT - 1) begin
                ph = 0; m_to = 1;
            end else begin
                wd++;
            end
        end
    endtask

    task automatic cycle(input bit c, input bit wr, input logic [6:0] d,
                         input bit r, input bit dn, input bit st);
        clr = c; instr_wr = wr; instr_in = d; run = r; done_in = dn;
`ifdef SINGLE_STEP_EN
        step = st;
`endif
        @(posedge clk);
        model_step(c, wr, d, r, dn, st);
        @(negedge clk);
    endtask

    task automatic rand_cycles(input int n, input int pw, input int pd, input int pr, input int ps);
        for (int i = 0; i < n; i++)
            cycle(0, ($urandom % 100) < pw, 7'($urandom), ($urandom % 100) < pr,
                  ($urandom % 100) < pd, ($urandom % 100) < ps);
    endtask

    // Monitor: every issued W pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (w_out) begin
                if (exp_q.size() == 0) check("unexpected_w_pulse", 32'(func_out), 32'hFFFF);
                else check("issue_func", 32'(func_out), 32'(exp_q.pop_front()));
            end
            check("w_out", 32'(w_out), 32'(m_w));
            check("func_out", 32'(func_out), 32'(m_func));
            check("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
            check("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
            check("busy", 32'(busy), 32'(ph != 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("timeout_err", 32'(timeout_err), 32'(m_to));
            check("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
        end
    end

    initial begin
        cycle(1, 0, 0, 0, 0, 0);
        mon_en = 1;
        cycle(1, 0, 0, 0, 0, 0);

        // single instruction, done two cycles after W
        cycle(0, 1, 7'h04, 1, 0, 1);
        cycle(0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 1, 1, 1);
        cycle(0, 0, 0, 1, 0, 1);

        // overfill with run low, then drain in order
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 1, 7'(i * 11 + 3), 0, 0, 1);
        for (int i = 0; i < 60; i++) cycle(0, 0, 0, 1, (i % 3) == 2, 1);

        // full FIFO, write coinciding with the pop
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 7'($urandom), 0, 0, 1);
        cycle(0, 1, 7'h5A, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // watchdog: no done at all while entries are queued
        for (int i = 0; i < 40; i++) cycle(0, 0, 0, 1, 0, 1);

        // random traffic
        cycle(1, 0, 0, 0, 0, 0);
        rand_cycles(400, 50, 30, 80, 40);
        rand_cycles(200, 30, 5, 90, 60);

        // reset while waiting for done
        for (int i = 0; i < 3; i++) cycle(0, 1, 7'($urandom), 1, 0, 1);
        for (int i = 0; i < 20 && ph != 2; i++) cycle(0, 0, 0, 1, 0, 1);
        check("reached_wait", 32'(ph), 32'd2);
        cycle(1, 0, 0, 1, 0, 1);
        rand_cycles(200, 40, 25, 70, 50);

        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 1, 0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
